ro_window_ctrl: RTL and testbench

//  Measurement-window controller placed directly upstream of the 8-bit up counter.

---
 rtl/ro_window_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ro_window_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_window_ctrl.sv
// ro_window_ctrl: measurement-window controller for an external WIDTH-bit up counter.
// Synchronises a ring-oscillator input, gates its rising edges into the counter for a
// programmed number of clk cycles, then returns the captured count over valid/ready.
// Optional feature macro: RO_WINDOW_OVF_EN (sticky counter-wrap flag reported as o_result_ovf).
module ro_window_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_start_val,
  input  logic [WIN_W-1:0] i_window_len,
  input  logic             i_ro_in,
  output logic [WIDTH-1:0] o_cnt_start,
  output logic             o_cnt_reset,
  output logic             o_cnt_enable,
  input  logic [WIDTH-1:0] i_cnt_value,
  output logic             o_busy,
  output logic             o_result_valid,
  input  logic             i_result_ready,
  output logic [WIDTH-1:0] o_result_count,
  output logic [WIDTH-1:0] o_result_delta,
  output logic             o_result_ovf
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COUNT  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   w_edge_p;
  logic [WIN_W-1:0]       r_win_cnt;
  logic [WIN_W-1:0]       w_win_cnt_nxt;
  logic                   r_settle;
  logic                   w_settle_nxt;
  logic [WIDTH-1:0]       r_cnt_start;
  logic [WIDTH-1:0]       w_cnt_start_nxt;
  logic                   r_cnt_reset;
  logic                   w_cnt_reset_nxt;
  logic                   r_cnt_enable;
  logic                   w_cnt_enable_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   r_valid;
  logic                   w_valid_nxt;
  logic [WIDTH-1:0]       r_count;
  logic [WIDTH-1:0]       w_count_nxt;
  logic [WIDTH-1:0]       r_delta;
  logic [WIDTH-1:0]       w_delta_nxt;
  logic                   w_capture;

  // Synchroniser chain plus one delay flop for rising-edge detection
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_ro_in};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge_p = r_sync[SYNC_STAGES-1] & ~r_sync_d;

  // Result fields are captured on the final SETTLE cycle
  assign w_capture = (r_state == S_SETTLE) && r_settle;

  // State and registered-output update
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_win_cnt    <= '0;
      r_settle     <= 1'b0;
      r_cnt_start  <= '0;
      r_cnt_reset  <= 1'b1;
      r_cnt_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_count      <= '0;
      r_delta      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_win_cnt    <= w_win_cnt_nxt;
      r_settle     <= w_settle_nxt;
      r_cnt_start  <= w_cnt_start_nxt;
      r_cnt_reset  <= w_cnt_reset_nxt;
      r_cnt_enable <= w_cnt_enable_nxt;
      r_busy       <= w_busy_nxt;
      r_valid      <= w_valid_nxt;
      r_count      <= w_count_nxt;
      r_delta      <= w_delta_nxt;
    end
  end

  // Next-state and next-output decode; outputs are registered so they follow next state
  always_comb begin
    w_state_nxt      = r_state;
    w_win_cnt_nxt    = r_win_cnt;
    w_settle_nxt     = r_settle;
    w_cnt_start_nxt  = r_cnt_start;
    w_cnt_reset_nxt  = 1'b0;
    w_cnt_enable_nxt = 1'b0;
    w_valid_nxt      = r_valid;
    w_count_nxt      = r_count;
    w_delta_nxt      = r_delta;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_cnt_start_nxt = i_start_val;
          w_win_cnt_nxt   = i_window_len;
          w_cnt_reset_nxt = 1'b1;
          w_state_nxt     = S_LOAD;
        end
      end
      S_LOAD: begin
        w_settle_nxt = 1'b0;
        w_state_nxt  = (r_win_cnt == '0) ? S_SETTLE : S_COUNT;
      end
      S_COUNT: begin
        w_cnt_enable_nxt = w_edge_p;
        w_win_cnt_nxt    = r_win_cnt - WIN_W'(1);
        if (r_win_cnt == WIN_W'(1)) begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle) begin
          w_settle_nxt = 1'b0;
          w_count_nxt  = i_cnt_value;
          w_delta_nxt  = i_cnt_value - r_cnt_start;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = S_DONE;
        end else begin
          w_settle_nxt = 1'b1;
        end
      end
      S_DONE: begin
        if (i_result_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

`ifdef RO_WINDOW_OVF_EN
  logic r_ovf;
  logic r_res_ovf;

  // Sticky wrap flag, cleared on LOAD and captured with the other result fields
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ovf     <= 1'b0;
      r_res_ovf <= 1'b0;
    end else begin
      if (r_state == S_LOAD) begin
        r_ovf <= 1'b0;
      end else if (r_cnt_enable && (i_cnt_value == '1)) begin
        r_ovf <= 1'b1;
      end
      if (w_capture) begin
        r_res_ovf <= r_ovf;
      end
    end
  end

  assign o_result_ovf = r_res_ovf;
`else
  logic w_capture_unused;

  assign w_capture_unused = w_capture;
  assign o_result_ovf     = 1'b0;
`endif

  assign o_cnt_start    = r_cnt_start;
  assign o_cnt_reset    = r_cnt_reset;
  assign o_cnt_enable   = r_cnt_enable;
  assign o_busy         = r_busy;
  assign o_result_valid = r_valid;
  assign o_result_count = r_count;
  assign o_result_delta = r_delta;

endmodule

// File: tb/tb_ro_window_ctrl.sv
// Testbench for ro_window_ctrl: an up-counter model closes the loop; table vectors,
// hand-written reset/handshake sequences and randomized windows checked against a model.
module tb_ro_window_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned WIN_W = 16;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned NBITS = 128;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] start_val;
  logic [WIN_W-1:0] window_len;
  logic             ro_in;
  logic [WIDTH-1:0] cnt_start;
  logic             cnt_reset;
  logic             cnt_enable;
  logic [WIDTH-1:0] cnt_value;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result_count;
  logic [WIDTH-1:0] result_delta;
  logic             result_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // ro_in value sampled at the k-th rising edge after (and including) the accept edge
  logic ro_bits [0:NBITS-1];

  typedef struct {
    logic [WIDTH-1:0] sv;
    logic [WIN_W-1:0] w;
    int               n_edges;
    int               off;
    logic [WIDTH-1:0] ec;
    logic [WIDTH-1:0] ed;
    logic             eo;
  } vec_t;

  vec_t tbl [7];

  ro_window_ctrl #(.WIDTH(WIDTH), .WIN_W(WIN_W), .SYNC_STAGES(SYNC)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_start        (start),
    .i_start_val    (start_val),
    .i_window_len   (window_len),
    .i_ro_in        (ro_in),
    .o_cnt_start    (cnt_start),
    .o_cnt_reset    (cnt_reset),
    .o_cnt_enable   (cnt_enable),
    .i_cnt_value    (cnt_value),
    .o_busy         (busy),
    .o_result_valid (result_valid),
    .i_result_ready (result_ready),
    .o_result_count (result_count),
    .o_result_delta (result_delta),
    .o_result_ovf   (result_ovf)
  );

  always #5 clk = ~clk;

  // Downstream 8-bit up counter: synchronous load on reset strobe, increment on enable
  always @(posedge clk) begin
    if (cnt_reset) cnt_value <= cnt_start;
    else if (cnt_enable) cnt_value <= cnt_value + 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ovf_exp(input logic eo);
`ifdef RO_WINDOW_OVF_EN
    return eo;
`else
    return 1'b0 & eo;
`endif
  endfunction

  // Reference: rising edges of ro_in whose synchronised pulse lands inside the
  // window_len COUNT cycles (cycles 1..w after the accept edge)
  function automatic int model_rises(input int w);
    int   n = 0;
    logic prev = 1'b0;
    for (int t = 0; t < int'(NBITS); t++) begin
      if (ro_bits[t] && !prev && (t + int'(SYNC) - 1 >= 1) && (t + int'(SYNC) - 1 <= w)) n++;
      prev = ro_bits[t];
    end
    return n;
  endfunction

  task automatic clear_bits();
    for (int t = 0; t < int'(NBITS); t++) ro_bits[t] = 1'b0;
  endtask

  task automatic idle(input int n);
    ro_in        = 1'b0;
    start        = 1'b0;
    result_ready = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One full measurement starting at a negedge with ro_in low for several cycles
  task automatic measure(input logic [WIDTH-1:0] sv, input logic [WIN_W-1:0] w,
                         input int rdly, input bit poke,
                         input logic [WIDTH-1:0] ec, input logic [WIDTH-1:0] ed,
                         input logic eo);
    int last;
    last = 3 + int'(w);
    for (int k = 0; k <= last; k++) begin
      ro_in      = (k < int'(NBITS)) ? ro_bits[k] : 1'b0;
      start      = (k == 0) || (poke && k == 2);
      start_val  = (k == 0) ? sv : ~sv;
      window_len = (k == 0) ? w : WIN_W'(5);
      @(negedge clk);
      start = 1'b0;
      if (k == 0) chk("busy_after_accept", 32'(busy), 32'd1);
      chk($sformatf("valid_at_cycle_%0d", k + 1), 32'(result_valid), 32'(k == last));
    end
    chk("result_count", 32'(result_count), 32'(ec));
    chk("result_delta", 32'(result_delta), 32'(ed));
    chk("result_ovf", 32'(result_ovf), 32'(ovf_exp(eo)));
    chk("cnt_start_latched", 32'(cnt_start), 32'(sv));
    for (int r = 0; r < rdly; r++) begin
      ro_in        = 1'b0;
      start        = poke && (r == 0);
      start_val    = ~sv;
      result_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("done_valid_held", 32'(result_valid), 32'd1);
      chk("done_count_stable", 32'(result_count), 32'(ec));
      chk("done_delta_stable", 32'(result_delta), 32'(ed));
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("valid_cleared_on_ready", 32'(result_valid), 32'd0);
    chk("idle_after_ready", 32'(busy), 32'd0);
    @(negedge clk);
    chk("no_queued_restart", 32'(busy), 32'd0);
  endtask

  initial begin
    int               rises;
    logic [WIDTH-1:0] sv;
    logic [WIN_W-1:0] w;

    rst_n        = 1'b1;
    start        = 1'b0;
    start_val    = '0;
    window_len   = '0;
    ro_in        = 1'b0;
    result_ready = 1'b0;

    tbl[0] = '{8'h10, 16'd20, 7,  3, 8'h17, 8'h07, 1'b0};
    tbl[1] = '{8'hA5, 16'd0,  0,  0, 8'hA5, 8'h00, 1'b0};
    tbl[2] = '{8'hFE, 16'd12, 5,  1, 8'h03, 8'h05, 1'b1};
    tbl[3] = '{8'hFF, 16'd1,  1,  0, 8'h00, 8'h01, 1'b1};
    tbl[4] = '{8'h20, 16'd4,  1,  4, 8'h20, 8'h00, 1'b0};
    tbl[5] = '{8'h20, 16'd4,  1,  3, 8'h21, 8'h01, 1'b0};
    tbl[6] = '{8'h7F, 16'd40, 16, 5, 8'h8F, 8'h10, 1'b0};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_cnt_reset", 32'(cnt_reset), 32'd1);
    chk("rst_cnt_enable", 32'(cnt_enable), 32'd0);
    chk("rst_cnt_start", 32'(cnt_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_count", 32'(result_count), 32'd0);
    chk("rst_delta", 32'(result_delta), 32'd0);
    chk("rst_ovf", 32'(result_ovf), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("idle_cnt_reset_low", 32'(cnt_reset), 32'd0);
    idle(2);

    // Directed table vectors; first one also pokes start during COUNT/DONE and stalls ready
    for (int i = 0; i < 7; i++) begin
      clear_bits();
      for (int e = 0; e < tbl[i].n_edges; e++) ro_bits[tbl[i].off + 2 * e] = 1'b1;
      measure(tbl[i].sv, tbl[i].w, (i == 0) ? 10 : (i % 3), (i == 0),
              tbl[i].ec, tbl[i].ed, tbl[i].eo);
      idle(3);
    end

    // Reset asserted mid-COUNT, then a clean restart
    clear_bits();
    start      = 1'b1;
    start_val  = 8'h55;
    window_len = 16'd30;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ro_in = k[0];
      @(negedge clk);
    end
    chk("busy_before_midreset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cnt_reset", 32'(cnt_reset), 32'd1);
    chk("midrst_cnt_enable", 32'(cnt_enable), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_cnt_start", 32'(cnt_start), 32'd0);
    ro_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    ro_bits[0] = 1'b1;
    ro_bits[2] = 1'b1;
    measure(8'h00, 16'd4, 1, 1'b0, 8'h02, 8'h02, 1'b0);
    idle(3);

    // Randomized windows against the edge-counting model
    for (int it = 0; it < 25; it++) begin
      sv = WIDTH'($urandom);
      w  = WIN_W'($urandom_range(0, 24));
      clear_bits();
      for (int t = 0; t < int'(w) + 6; t++) ro_bits[t] = 1'($urandom % 2);
      rises = model_rises(int'(w));
      measure(sv, w, int'($urandom_range(0, 3)), 1'($urandom % 2),
              WIDTH'(int'(sv) + rises), WIDTH'(rises), (int'(sv) + rises) >= 256);
      idle(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
